eth_rx: RTL and testbench

ETH_RX -- requirements
Module: eth_rx

---
 rtl/eth_pkg.sv | 30 +++
 rtl/eth_rx_stats.sv | 41 ++++
 rtl/eth_rx.sv | 170 +++++++++++++++++
 tb/tb_eth_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// ============================================================================
// Module   : eth_pkg
// Brief    : Shared types and queue-word layout for the eth_rx ingress framer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package eth_pkg;

  localparam int WORD_W    = 34;
  localparam int START_BIT = 32;
  localparam int END_BIT   = 33;
  localparam int DATA_W    = 32;
  localparam int STAT_W    = 16;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_PASS    = 2'd1,
    RX_DISCARD = 2'd2
  } rx_state_t;

  function automatic logic [WORD_W-1:0] pack_word(input logic        end_f,
                                                  input logic        start_f,
                                                  input logic [31:0] data);
    return {end_f, start_f, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/eth_rx_stats.sv
// ============================================================================
// Module   : eth_rx_stats
// Brief    : Saturating packet and drop counters for eth_rx.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eth_rx_stats
  import eth_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_pkt_inc,
  input  logic              i_drop_inc,
  output logic [STAT_W-1:0] o_pkt_cnt,
  output logic [STAT_W-1:0] o_drop_cnt
);

  logic [STAT_W-1:0] r_pkt_cnt;
  logic [STAT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (i_pkt_inc && (r_pkt_cnt != {STAT_W{1'b1}})) begin
        r_pkt_cnt <= r_pkt_cnt + STAT_W'(1);
      end
      if (i_drop_inc && (r_drop_cnt != {STAT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + STAT_W'(1);
      end
    end
  end

  assign o_pkt_cnt  = r_pkt_cnt;
  assign o_drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: rtl/eth_rx.sv
// ============================================================================
// Module   : eth_rx
// Brief    : Ingress packet framer; admits, drops or truncates packets so the
//            queue always sees well-formed {end,start,data} streams.
// Options  : ETH_RX_STATS_EN adds the eth_rx_stats counter block.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eth_rx
  import eth_pkg::*;
#(
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  input  logic [31:0]       i_data,
  input  logic              i_start,
  input  logic              i_end,
  input  logic              almost_full,
  input  logic              full,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_data,
  output logic              o_drop,
  output logic              o_err,
  output logic [STAT_W-1:0] pkt_cnt,
  output logic [STAT_W-1:0] drop_cnt
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  rx_state_t         r_state, w_state_nxt;
  logic              r_hold_vld, w_hold_vld_nxt;
  logic              r_hold_start, w_hold_start_nxt;
  logic [31:0]       r_hold_data, w_hold_data_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_pend_vld, w_pend_vld_nxt;
  logic [WORD_W-1:0] r_pend_word, w_pend_word_nxt;
  logic              r_drop, w_drop_nxt;
  logic              r_err, w_err_nxt;

  logic              w_hold_wr;
  logic [WORD_W-1:0] w_hold_word;
  logic              w_take_start;
  logic              w_acc;
  logic              w_acc_start;
  logic [CNT_W-1:0]  w_acc_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= RX_IDLE;
      r_hold_vld   <= 1'b0;
      r_hold_start <= 1'b0;
      r_hold_data  <= '0;
      r_count      <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_word  <= '0;
      r_drop       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_vld   <= w_hold_vld_nxt;
      r_hold_start <= w_hold_start_nxt;
      r_hold_data  <= w_hold_data_nxt;
      r_count      <= w_count_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_pend_word  <= w_pend_word_nxt;
      r_drop       <= w_drop_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // The held word leaves as soon as its successor arrives; a terminating word
  // goes to r_pend_* and leaves on the next cycle, so the two never collide.
  always_comb begin
    w_state_nxt      = r_state;
    w_hold_vld_nxt   = r_hold_vld;
    w_hold_start_nxt = r_hold_start;
    w_hold_data_nxt  = r_hold_data;
    w_count_nxt      = r_count;
    w_pend_vld_nxt   = 1'b0;
    w_pend_word_nxt  = r_pend_word;
    w_drop_nxt       = 1'b0;
    w_err_nxt        = 1'b0;
    w_hold_wr        = 1'b0;
    w_hold_word      = pack_word(1'b0, r_hold_start, r_hold_data);
    w_take_start     = 1'b0;
    w_acc            = 1'b0;
    w_acc_start      = 1'b0;
    w_acc_cnt        = r_count + CNT_W'(1);

    if (i_valid) begin
      case (r_state)
        RX_PASS: begin
          w_hold_wr = r_hold_vld;
          if (i_start) begin
            w_hold_word[END_BIT] = 1'b1;
            w_err_nxt            = 1'b1;
            w_take_start         = 1'b1;
          end else begin
            w_acc = 1'b1;
          end
        end
        RX_DISCARD: begin
          if (i_start) begin
            w_take_start = 1'b1;
          end else if (i_end) begin
            w_state_nxt = RX_IDLE;
          end
        end
        default: w_take_start = i_start;
      endcase
    end

    if (w_take_start) begin
      w_hold_vld_nxt = 1'b0;
      if (almost_full) begin
        w_drop_nxt  = 1'b1;
        w_state_nxt = i_end ? RX_IDLE : RX_DISCARD;
      end else begin
        w_acc       = 1'b1;
        w_acc_start = 1'b1;
        w_acc_cnt   = CNT_W'(1);
      end
    end

    if (w_acc) begin
      if (i_end || (w_acc_cnt == CNT_W'(MAX_WORDS))) begin
        w_pend_vld_nxt  = 1'b1;
        w_pend_word_nxt = pack_word(1'b1, w_acc_start, i_data);
        w_err_nxt       = w_err_nxt | ~i_end;
        w_hold_vld_nxt  = 1'b0;
        w_state_nxt     = i_end ? RX_IDLE : RX_DISCARD;
      end else begin
        w_hold_vld_nxt   = 1'b1;
        w_hold_start_nxt = w_acc_start;
        w_hold_data_nxt  = i_data;
        w_count_nxt      = w_acc_cnt;
        w_state_nxt      = RX_PASS;
      end
    end

    if (full && (w_hold_wr || r_pend_vld)) begin
      w_err_nxt = 1'b1;
    end
  end

  assign wr_en   = (w_hold_wr | r_pend_vld) & ~full;
  assign wr_data = w_hold_wr ? w_hold_word : r_pend_word;
  assign o_drop  = r_drop;
  assign o_err   = r_err;

`ifdef ETH_RX_STATS_EN
  eth_rx_stats u_stats (
    .clk        (clk),
    .rstn       (rstn),
    .i_pkt_inc  (wr_en & wr_data[END_BIT]),
    .i_drop_inc (r_drop),
    .o_pkt_cnt  (pkt_cnt),
    .o_drop_cnt (drop_cnt)
  );
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eth_rx.sv
// ============================================================================
// Module   : tb_eth_rx
// Brief    : Scoreboard bench for eth_rx with a packet-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_eth_rx;
  import eth_pkg::*;

  localparam int MAXW = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              i_valid, i_start, i_end, almost_full, full;
  logic [31:0]       i_data;
  logic              wr_en, o_drop, o_err;
  logic [WORD_W-1:0] wr_data;
  logic [15:0]       pkt_cnt, drop_cnt;

  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] mon_e;
  int checks = 0;
  int errors = 0;
  int exp_drops = 0, exp_errs = 0, seen_drops = 0, seen_errs = 0;
  int stat_pkts = 0, stat_drops = 0;

  always #5 clk = ~clk;

  eth_rx #(.MAX_WORDS(MAXW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_start     (i_start),
    .i_end       (i_end),
    .almost_full (almost_full),
    .full        (full),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .o_drop      (o_drop),
    .o_err       (o_err),
    .pkt_cnt     (pkt_cnt),
    .drop_cnt    (drop_cnt)
  );

  // Monitor: every queue write must match the head of the expected stream.
  always @(negedge clk) begin
    if (rstn) begin
      if (wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got %h expected none", wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (wr_data !== mon_e) begin
            errors++;
            $display("FAIL write_data got %h expected %h", wr_data, mon_e);
          end
        end
      end
      if (o_drop) seen_drops++;
      if (o_err)  seen_errs++;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [WORD_W-1:0] w);
    exp_q.push_back(w);
    if (w[END_BIT]) stat_pkts++;
  endtask

  task automatic idle_inputs();
    i_valid     = 1'b0;
    i_start     = 1'($urandom_range(0, 1));
    i_end       = 1'($urandom_range(0, 1));
    i_data      = $urandom;
    almost_full = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input bit s, input bit e, input bit af, input logic [31:0] d);
    i_valid     = 1'b1;
    i_start     = s;
    i_end       = e;
    almost_full = af;
    i_data      = d;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Packet-level model: a dropped packet yields nothing; an admitted one
  // yields its first min(len, MAXW) words with the last marked end, plus an
  // error when it was cut short by a new start or by the length limit.
  task automatic send_pkt(input int len, input bit af, input bit intr);
    logic [31:0] d[$];
    int n;
    for (int i = 0; i < len; i++) d.push_back($urandom);
    if (af) begin
      exp_drops++;
      stat_drops++;
    end else begin
      n = (len < MAXW) ? len : MAXW;
      for (int i = 0; i < n; i++) push_exp({(i == n - 1), (i == 0), d[i]});
      if (intr || len > MAXW) exp_errs++;
    end
    for (int i = 0; i < len; i++) begin
      drive(i == 0, !intr && (i == len - 1), (i == 0) ? af : 1'($urandom_range(0, 1)), d[i]);
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
    end
  endtask

  initial begin
    int  len;
    bit  af, intr;
    rstn = 1'b0;
    full = 1'b0;
    idle_inputs();
    #12;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_o_drop", o_drop, 0);
    chk("reset_o_err", o_err, 0);
    chk("reset_pkt_cnt", pkt_cnt, 0);
    chk("reset_drop_cnt", drop_cnt, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    gap(2);

    // Three-word packet: end word appears exactly one cycle after it is sampled.
    push_exp(34'h1_00000001);
    push_exp(34'h0_0000000A);
    push_exp(34'h2_0000000B);
    drive(1, 0, 0, 32'h1);
    drive(0, 0, 0, 32'hA);
    drive(0, 1, 0, 32'hB);
    chk("end_latency_wr_en", wr_en, 1);
    chk("end_latency_data", wr_data, 34'h2_0000000B);
    gap(1);
    chk("end_single_pulse", wr_en, 0);

    // Single-word packet.
    push_exp(34'h3_00000005);
    drive(1, 1, 0, 32'h5);
    chk("single_word_wr_en", wr_en, 1);
    chk("single_word_data", wr_data, 34'h3_00000005);
    gap(2);

    // Packet dropped on almost_full.
    exp_drops++;
    stat_drops++;
    drive(1, 0, 1, 32'h100);
    chk("drop_pulse", o_drop, 1);
    drive(0, 0, 0, 32'h101);
    chk("drop_single_pulse", o_drop, 0);
    drive(0, 0, 0, 32'h102);
    drive(0, 1, 0, 32'h103);
    gap(2);

    // Six-word packet truncated at MAXW words.
    for (int i = 0; i < MAXW; i++) push_exp({(i == MAXW - 1), (i == 0), 32'h200 + i});
    exp_errs++;
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, i == 5, 0, 32'h200 + i);
      if (i == MAXW - 1) chk("overflow_err", o_err, 1);
    end
    gap(2);

    // New start after two words closes the old packet with an error.
    push_exp(34'h1_00000300);
    push_exp(34'h2_00000301);
    push_exp(34'h1_00000400);
    push_exp(34'h0_00000401);
    push_exp(34'h2_00000402);
    exp_errs++;
    drive(1, 0, 0, 32'h300);
    drive(0, 0, 0, 32'h301);
    drive(1, 0, 0, 32'h400);
    chk("restart_err", o_err, 1);
    drive(0, 0, 0, 32'h401);
    drive(0, 1, 0, 32'h402);
    gap(2);

    // Reset mid-packet: held word is discarded, outputs clear at once.
    push_exp(34'h1_00000500);
    drive(1, 0, 0, 32'h500);
    drive(0, 0, 0, 32'h501);
    #2;
    rstn = 1'b0;
    #1;
    chk("midreset_wr_en", wr_en, 0);
    chk("midreset_wr_data", wr_data, 0);
    chk("midreset_o_drop", o_drop, 0);
    chk("midreset_o_err", o_err, 0);
    chk("midreset_queue_drained", exp_q.size(), 0);
    stat_pkts  = 0;
    stat_drops = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push_exp(34'h1_00000600);
    push_exp(34'h2_00000601);
    drive(0, 0, 0, 32'h5FF);
    drive(1, 0, 0, 32'h600);
    drive(0, 1, 0, 32'h601);
    gap(2);

    // Randomized packet stream.
    for (int p = 0; p < 60; p++) begin
      len  = $urandom_range(1, MAXW + 2);
      af   = ($urandom_range(0, 3) == 0);
      intr = (p != 59) && ($urandom_range(0, 3) == 0);
      send_pkt(len, af, intr);
      if (!intr && $urandom_range(0, 2) == 0)
        drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end
    gap(3);

    // Write while full is suppressed and flagged.
    full = 1'b1;
    exp_errs++;
    drive(1, 1, 0, 32'h700);
    chk("full_suppress", wr_en, 0);
    gap(1);
    chk("full_err", o_err, 1);
    full = 1'b0;
    gap(3);

    chk("queue_drained", exp_q.size(), 0);
    chk("drop_total", seen_drops, exp_drops);
    chk("err_total", seen_errs, exp_errs);
`ifdef ETH_RX_STATS_EN
    chk("stat_pkt_cnt", pkt_cnt, stat_pkts);
    chk("stat_drop_cnt", drop_cnt, stat_drops);
`else
    chk("stat_pkt_cnt_tied", pkt_cnt, 0);
    chk("stat_drop_cnt_tied", drop_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
